// File: rtl/dma_copy_master.sv
// DMA copy initiator: moves len 16-bit words src->dst on the MSP430 DMA port, one read beat then one write beat per word.
// Optional feature: define DMA_KEY_GUARD_EN to refuse any beat whose address falls inside the key-memory window.
module dma_copy_master #(
    parameter logic [15:0] KMEM_BASE = 16'hFEFE,
    parameter logic [15:0] KMEM_SIZE = 16'h001F,
    parameter int          LEN_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      dma_addr,
    output logic             dma_en,
    output logic [1:0]       dma_we,
    output logic [15:0]      dma_din,
    input  logic [15:0]      dma_dout,
    input  logic             dma_ready,
    input  logic             dma_resp
);

`ifdef DMA_KEY_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RDWAIT, S_WR, S_FINISH, S_ERR} state_t;

    state_t           state_q, state_d;
    logic [15:0]      src_q, src_d;
    logic [15:0]      dst_q, dst_d;
    logic [15:0]      data_q, data_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      next_src, next_dst;

    // Window end is computed in 17 bits so a region touching 16'hFFFF cannot wrap.
    function automatic logic in_kmem(input logic [15:0] a);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {1'b0, KMEM_BASE};
        hi = lo + {1'b0, KMEM_SIZE};
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    assign next_src = src_q + 16'd2;
    assign next_dst = dst_q + 16'd2;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        data_d   = data_q;
        rem_d    = rem_q;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_FINISH);
        err      = (state_q == S_ERR);
        dma_en   = 1'b0;
        dma_we   = 2'b00;
        dma_addr = '0;
        dma_din  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = len;
                    if (src_addr[0] || dst_addr[0])            state_d = S_ERR;
                    else if (len == '0)                        state_d = S_FINISH;
                    else if (GUARD_EN && in_kmem(src_addr))    state_d = S_ERR;
                    else                                       state_d = S_RD;
                end
            end
            S_RD: begin
                dma_en   = 1'b1;
                dma_addr = src_q;
                if (dma_ready) state_d = dma_resp ? S_ERR : S_RDWAIT;
            end
            S_RDWAIT: begin
                data_d = dma_dout;
                if (abort)                              state_d = S_ERR;
                else if (GUARD_EN && in_kmem(dst_q))    state_d = S_ERR;
                else                                    state_d = S_WR;
            end
            // The last word's completion takes priority over a simultaneous abort.
            S_WR: begin
                dma_en   = 1'b1;
                dma_we   = 2'b11;
                dma_addr = dst_q;
                dma_din  = data_q;
                if (dma_ready) begin
                    if (dma_resp) begin
                        state_d = S_ERR;
                    end else begin
                        src_d = next_src;
                        dst_d = next_dst;
                        rem_d = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1))                     state_d = S_FINISH;
                        else if (abort)                             state_d = S_ERR;
                        else if (GUARD_EN && in_kmem(next_src))     state_d = S_ERR;
                        else                                        state_d = S_RD;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_copy_master.sv
// Directed bench for dma_copy_master: a bus responder with programmable wait states, read faults and abort injection.
module tb_dma_copy_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src, dst;
    logic [7:0]  len;
    logic        abort;
    logic        busy, done, err;
    logic [15:0] dma_addr, dma_din, dma_dout;
    logic        dma_en, dma_ready, dma_resp;
    logic [1:0]  dma_we;

    int checks = 0;
    int errors = 0;

    int latency = 0, faultRead = 0, abortAtWrite = 0;
    int cycleCnt = 0, waitCnt = 0, unstable = 0, kmemEn = 0;
    int doneCnt = 0, errCnt = 0, busyRise = -1, busyFall = -1, doneCycle = -1, errCycle = -1;
    bit busyAtDone = 0, prevBusy = 0, newBeat = 1, rdPending = 0, to;
    logic [15:0] rdPendAddr, snapA, snapD;
    logic [1:0]  snapW;
    logic [15:0] rdLog[$], wrAddr[$], wrData[$];

    dma_copy_master dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src), .dst_addr(dst),
        .len(len), .abort(abort), .busy(busy), .done(done), .err(err),
        .dma_addr(dma_addr), .dma_en(dma_en), .dma_we(dma_we), .dma_din(dma_din),
        .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Bus responder and event monitor; everything is sampled and driven on the falling edge.
    initial begin
        dma_ready = 0; dma_resp = 0; dma_dout = 16'hDEAD; abort = 0;
        forever begin
            @(negedge clk);
            cycleCnt++;
            if (rdPending) begin dma_dout = model(rdPendAddr); rdPending = 0; end
            else dma_dout = 16'hDEAD;
            if (dma_en) begin
                if (newBeat) begin snapA = dma_addr; snapW = dma_we; snapD = dma_din; newBeat = 0; end
                else if ({dma_addr, dma_we, dma_din} != {snapA, snapW, snapD}) unstable++;
                if (dma_addr == 16'hFEFE) kmemEn++;
                if (abortAtWrite != 0 && dma_we == 2'b11 && wrAddr.size() == abortAtWrite - 1) abort = 1;
                if (waitCnt < latency) begin
                    waitCnt++; dma_ready = 0; dma_resp = 0;
                end else begin
                    dma_ready = 1; dma_resp = 0; newBeat = 1; waitCnt = 0;
                    if (dma_we == 2'b11) begin
                        wrAddr.push_back(dma_addr); wrData.push_back(dma_din);
                    end else begin
                        rdLog.push_back(dma_addr);
                        if (faultRead == rdLog.size()) dma_resp = 1;
                        else begin rdPending = 1; rdPendAddr = dma_addr; end
                    end
                end
            end else begin
                dma_ready = 0; dma_resp = 0; newBeat = 1; waitCnt = 0;
            end
            if (busy && !prevBusy) busyRise = cycleCnt;
            if (!busy && prevBusy) busyFall = cycleCnt;
            if (done) begin doneCnt++; doneCycle = cycleCnt; busyAtDone = busy; abort = 0; end
            if (err) begin errCnt++; errCycle = cycleCnt; abort = 0; end
            prevBusy = busy;
        end
    end

    task automatic startXfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                             input int lat, input int fr, input int aw);
        @(negedge clk);
        rdLog.delete(); wrAddr.delete(); wrData.delete();
        doneCnt = 0; errCnt = 0; unstable = 0; kmemEn = 0;
        busyRise = -1; busyFall = -1; doneCycle = -1; errCycle = -1; busyAtDone = 0;
        latency = lat; faultRead = fr; abortAtWrite = aw;
        src = s; dst = d; len = n; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic waitIdle(output bit timedOut);
        int k = 0;
        while (busy && k < 500) begin @(negedge clk); k++; end
        timedOut = (k >= 500);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 0; start = 0; src = 0; dst = 0; len = 0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0)       begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++; if (dma_en !== 1'b0)    begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", dma_en); end
        checks++; if (dma_we !== 2'b00)   begin errors++; $display("[TB] FAIL reset_we: got %b expected 00", dma_we); end
        checks++; if (dma_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0000", dma_addr); end
        checks++; if (dma_din !== 16'h0)  begin errors++; $display("[TB] FAIL reset_din: got %h expected 0000", dma_din); end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic_copy;
        logic [15:0] e;
        startXfer(16'h0200, 16'h0300, 8'd4, 0, 0, 0);
        waitIdle(to);
        checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: busy still 1 expected 0"); end
        checks++; if (rdLog.size() !== 4)  begin errors++; $display("[TB] FAIL basic_reads: got %0d expected 4", rdLog.size()); end
        checks++; if (wrAddr.size() !== 4) begin errors++; $display("[TB] FAIL basic_writes: got %0d expected 4", wrAddr.size()); end
        for (int i = 0; i < 4; i++) begin
            e = 16'h0200 + 16'(2 * i);
            if (i < rdLog.size()) begin
                checks++; if (rdLog[i] !== e) begin errors++; $display("[TB] FAIL basic_raddr%0d: got %h expected %h", i, rdLog[i], e); end
            end
            if (i < wrAddr.size()) begin
                checks++; if (wrAddr[i] !== 16'h0300 + 16'(2 * i)) begin errors++; $display("[TB] FAIL basic_waddr%0d: got %h expected %h", i, wrAddr[i], 16'h0300 + 16'(2 * i)); end
                checks++; if (wrData[i] !== model(e)) begin errors++; $display("[TB] FAIL basic_wdata%0d: got %h expected %h", i, wrData[i], model(e)); end
            end
        end
        checks++; if (doneCnt !== 1) begin errors++; $display("[TB] FAIL basic_done: got %0d pulses expected 1", doneCnt); end
        checks++; if (errCnt !== 0)  begin errors++; $display("[TB] FAIL basic_err: got %0d pulses expected 0", errCnt); end
        checks++; if (doneCycle - busyRise !== 12) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 12", doneCycle - busyRise); end
        checks++; if (busyAtDone !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b expected 1", busyAtDone); end
    endtask

    task automatic test_wait_states;
        startXfer(16'h0220, 16'h0320, 8'd1, 3, 0, 0);
        waitIdle(to);
        checks++; if (to) begin errors++; $display("[TB] FAIL wait_timeout: busy still 1 expected 0"); end
        checks++; if (unstable !== 0) begin errors++; $display("[TB] FAIL wait_stable: got %0d changes expected 0", unstable); end
        checks++; if (wrAddr.size() !== 1 || wrData[0] !== model(16'h0220)) begin errors++; $display("[TB] FAIL wait_write: got %0d writes expected 1 with data %h", wrAddr.size(), model(16'h0220)); end
        checks++; if (doneCnt !== 1) begin errors++; $display("[TB] FAIL wait_done: got %0d pulses expected 1", doneCnt); end
        checks++; if (doneCycle - busyRise !== 9) begin errors++; $display("[TB] FAIL wait_latency: got %0d expected 9", doneCycle - busyRise); end
    endtask

    task automatic test_wrap;
        startXfer(16'hFFFC, 16'h0400, 8'd3, 0, 0, 0);
        waitIdle(to);
        checks++; if (to) begin errors++; $display("[TB] FAIL wrap_timeout: busy still 1 expected 0"); end
        checks++; if (rdLog.size() !== 3) begin errors++; $display("[TB] FAIL wrap_reads: got %0d expected 3", rdLog.size()); end
        else begin
            checks++; if (rdLog[1] !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_raddr1: got %h expected FFFE", rdLog[1]); end
            checks++; if (rdLog[2] !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_raddr2: got %h expected 0000", rdLog[2]); end
        end
        checks++; if (wrData.size() !== 3 || wrData[2] !== model(16'h0000)) begin errors++; $display("[TB] FAIL wrap_wdata: got %0d writes expected 3 ending with %h", wrData.size(), model(16'h0000)); end
        checks++; if (doneCnt !== 1) begin errors++; $display("[TB] FAIL wrap_done: got %0d pulses expected 1", doneCnt); end
    endtask

    task automatic test_zero_len;
        startXfer(16'h0200, 16'h0300, 8'd0, 0, 0, 0);
        waitIdle(to);
        checks++; if (doneCnt !== 1 || errCnt !== 0) begin errors++; $display("[TB] FAIL zero_pulses: got done=%0d err=%0d expected 1/0", doneCnt, errCnt); end
        checks++; if (rdLog.size() + wrAddr.size() !== 0) begin errors++; $display("[TB] FAIL zero_beats: got %0d expected 0", rdLog.size() + wrAddr.size()); end
        checks++; if (doneCycle !== busyRise) begin errors++; $display("[TB] FAIL zero_timing: got done at %0d expected %0d", doneCycle, busyRise); end
        checks++; if (busyFall - doneCycle !== 1) begin errors++; $display("[TB] FAIL zero_busy_fall: got %0d expected 1", busyFall - doneCycle); end
    endtask

    task automatic test_misaligned;
        startXfer(16'h0201, 16'h0300, 8'd2, 0, 0, 0);
        waitIdle(to);
        checks++; if (errCnt !== 1 || doneCnt !== 0) begin errors++; $display("[TB] FAIL odd_src_pulses: got err=%0d done=%0d expected 1/0", errCnt, doneCnt); end
        checks++; if (rdLog.size() + wrAddr.size() !== 0) begin errors++; $display("[TB] FAIL odd_src_beats: got %0d expected 0", rdLog.size() + wrAddr.size()); end
        startXfer(16'h0200, 16'h0301, 8'd2, 0, 0, 0);
        waitIdle(to);
        checks++; if (errCnt !== 1 || doneCnt !== 0) begin errors++; $display("[TB] FAIL odd_dst_pulses: got err=%0d done=%0d expected 1/0", errCnt, doneCnt); end
        checks++; if (rdLog.size() + wrAddr.size() !== 0) begin errors++; $display("[TB] FAIL odd_dst_beats: got %0d expected 0", rdLog.size() + wrAddr.size()); end
    endtask

    task automatic test_read_fault;
        startXfer(16'h0200, 16'h0300, 8'd4, 0, 2, 0);
        waitIdle(to);
        checks++; if (errCnt !== 1 || doneCnt !== 0) begin errors++; $display("[TB] FAIL rfault_pulses: got err=%0d done=%0d expected 1/0", errCnt, doneCnt); end
        checks++; if (wrAddr.size() !== 1) begin errors++; $display("[TB] FAIL rfault_writes: got %0d expected 1", wrAddr.size()); end
        checks++; if (rdLog.size() !== 2) begin errors++; $display("[TB] FAIL rfault_reads: got %0d expected 2", rdLog.size()); end
        checks++; if (busyFall - errCycle !== 1) begin errors++; $display("[TB] FAIL rfault_busy_fall: got %0d expected 1", busyFall - errCycle); end
    endtask

    task automatic test_abort;
        startXfer(16'h0200, 16'h0300, 8'd5, 2, 0, 2);
        waitIdle(to);
        checks++; if (errCnt !== 1 || doneCnt !== 0) begin errors++; $display("[TB] FAIL abort_pulses: got err=%0d done=%0d expected 1/0", errCnt, doneCnt); end
        checks++; if (wrAddr.size() !== 2) begin errors++; $display("[TB] FAIL abort_writes: got %0d expected 2", wrAddr.size()); end
        checks++; if (rdLog.size() !== 2) begin errors++; $display("[TB] FAIL abort_reads: got %0d expected 2", rdLog.size()); end
    endtask

    task automatic test_abort_last;
        startXfer(16'h0200, 16'h0300, 8'd2, 2, 0, 2);
        waitIdle(to);
        checks++; if (doneCnt !== 1 || errCnt !== 0) begin errors++; $display("[TB] FAIL abort_last_pulses: got done=%0d err=%0d expected 1/0", doneCnt, errCnt); end
        checks++; if (wrAddr.size() !== 2) begin errors++; $display("[TB] FAIL abort_last_writes: got %0d expected 2", wrAddr.size()); end
    endtask

    task automatic test_ignore_start;
        startXfer(16'h0500, 16'h0580, 8'd2, 0, 0, 0);
        src = 16'h0700; dst = 16'h0780; len = 8'd9; start = 1;
        repeat (2) @(negedge clk);
        start = 0;
        waitIdle(to);
        checks++; if (rdLog.size() !== 2) begin errors++; $display("[TB] FAIL ignore_reads: got %0d expected 2", rdLog.size()); end
        else begin
            checks++; if (rdLog[1] !== 16'h0502) begin errors++; $display("[TB] FAIL ignore_raddr: got %h expected 0502", rdLog[1]); end
        end
        checks++; if (wrAddr.size() !== 2 || wrAddr[1] !== 16'h0582) begin errors++; $display("[TB] FAIL ignore_waddr: got %0d writes expected 2 ending at 0582", wrAddr.size()); end
        checks++; if (doneCnt !== 1) begin errors++; $display("[TB] FAIL ignore_done: got %0d pulses expected 1", doneCnt); end
    endtask

    task automatic test_key_region;
        startXfer(16'h0600, 16'hFEFA, 8'd4, 0, 0, 0);
        waitIdle(to);
`ifdef DMA_KEY_GUARD_EN
        checks++; if (wrAddr.size() !== 2) begin errors++; $display("[TB] FAIL kmem_writes: got %0d expected 2", wrAddr.size()); end
        checks++; if (errCnt !== 1 || doneCnt !== 0) begin errors++; $display("[TB] FAIL kmem_pulses: got err=%0d done=%0d expected 1/0", errCnt, doneCnt); end
        checks++; if (kmemEn !== 0) begin errors++; $display("[TB] FAIL kmem_en: got %0d cycles expected 0", kmemEn); end
`else
        checks++; if (wrAddr.size() !== 4 || wrAddr[2] !== 16'hFEFE) begin errors++; $display("[TB] FAIL kmem_writes: got %0d writes expected 4 incl FEFE", wrAddr.size()); end
        checks++; if (doneCnt !== 1 || errCnt !== 0) begin errors++; $display("[TB] FAIL kmem_pulses: got done=%0d err=%0d expected 1/0", doneCnt, errCnt); end
        checks++; if (kmemEn !== 1) begin errors++; $display("[TB] FAIL kmem_en: got %0d cycles expected 1", kmemEn); end
`endif
    endtask

    task automatic test_async_reset;
        startXfer(16'h0200, 16'h0300, 8'd3, 20, 0, 0);
        @(negedge clk);
        checks++; if (dma_en !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_en: got %b expected 1", dma_en); end
        #2 reset_n = 0;
        #1;
        checks++; if (dma_en !== 1'b0)    begin errors++; $display("[TB] FAIL areset_en: got %b expected 0", dma_en); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (dma_addr !== 16'h0) begin errors++; $display("[TB] FAIL areset_addr: got %h expected 0000", dma_addr); end
        @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || dma_en !== 1'b0) begin errors++; $display("[TB] FAIL areset_idle: got busy=%b en=%b expected 0/0", busy, dma_en); end
    endtask

    initial begin
        test_reset;
        test_basic_copy;
        test_wait_states;
        test_wrap;
        test_zero_len;
        test_misaligned;
        test_read_fault;
        test_abort;
        test_abort_last;
        test_ignore_start;
        test_key_region;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
